// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on both sides and a flush kill.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state;
    state_t              state_next;

    logic [2:0]          op_q;
    logic [XLEN-1:0]     operand;
    logic [2*XLEN-1:0]   prod;
    logic [CW-1:0]       counter;
    logic                neg_res;
    logic                neg_rem;

    // operand decode at the input side
    logic                is_div;
    logic                sign1;
    logic                sign2;
    logic                neg1;
    logic                neg2;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic                div_zero;
    logic                div_ovf;
    logic                special;
    logic [XLEN-1:0]     special_res;
    logic                accept;

    // iteration and fix-up datapath
    logic [XLEN:0]       sum;
    logic [XLEN:0]       shifted;
    logic [XLEN:0]       diff;
    logic                ge;
    logic [2*XLEN-1:0]   mul_step;
    logic [2*XLEN-1:0]   div_step;
    logic [2*XLEN-1:0]   step;
    logic [2*XLEN-1:0]   prod_fixed;
    logic [XLEN-1:0]     quo_fixed;
    logic [XLEN-1:0]     rem_fixed;
    logic [XLEN-1:0]     fix_res;

    always_comb begin
        is_div   = op[2];
        // MUL/MULH sign both operands, MULHSU only in1; DIVU/REMU have op[0] set
        sign1    = is_div ? !op[0] : (op[1:0] != 2'b11);
        sign2    = is_div ? !op[0] : !op[1];
        neg1     = sign1 & in1[XLEN-1];
        neg2     = sign2 & in2[XLEN-1];
        mag1     = neg1 ? ('0 - in1) : in1;
        mag2     = neg2 ? ('0 - in2) : in2;
        div_zero = is_div && (in2 == '0);
        div_ovf  = is_div && !op[0] && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
        special  = div_zero || div_ovf;
        if (op[1])
            special_res = div_zero ? in1 : '0;
        else
            special_res = div_zero ? '1 : in1;
        accept   = in_valid && in_ready && !flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = special ? DONE : CALC;
                CALC:    if (counter == '0) state_next = FIX;
                FIX:     state_next = DONE;
                DONE:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    always_comb begin
        sum      = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, operand} : '0);
        mul_step = {sum, prod[XLEN-1:1]};
        // partial remainder shifted left with the next dividend bit brought in
        shifted  = prod[2*XLEN-1:XLEN-1];
        diff     = shifted - {1'b0, operand};
        ge       = !diff[XLEN];
        div_step = {(ge ? diff[XLEN-1:0] : shifted[XLEN-1:0]), prod[XLEN-2:0], ge};
        step     = op_q[2] ? div_step : mul_step;
    end

    always_comb begin
        prod_fixed = neg_res ? ('0 - prod) : prod;
        quo_fixed  = neg_res ? ('0 - prod[XLEN-1:0]) : prod[XLEN-1:0];
        rem_fixed  = neg_rem ? ('0 - prod[2*XLEN-1:XLEN]) : prod[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                fix_res = prod_fixed[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fixed[2*XLEN-1:XLEN];
            3'b100, 3'b101:        fix_res = quo_fixed;
            default:               fix_res = rem_fixed;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            operand <= '0;
            prod    <= '0;
            counter <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            out     <= '0;
        end else if (accept) begin
            op_q    <= op;
            operand <= is_div ? mag2 : mag1;
            prod    <= {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
            counter <= CW'(XLEN-1);
            neg_res <= neg1 ^ neg2;
            neg_rem <= neg1;
            if (special)
                out <= special_res;
        end else if (state == CALC) begin
            prod    <= step;
            counter <= counter - CW'(1);
        end else if (state == FIX) begin
            out     <= fix_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, abort/backpressure sequences and
// random operations compared against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam int ITER_LAT = XLEN + 1;  // edges after the accept edge until out_valid

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out;
    logic            busy;

    int nvec = 0;
    int nmis = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tv[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, sp;
        logic [63:0]        ua, uu, up;
        int                 ia, ib;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ub = {32'h0, b};
        ua = {32'h0, a};
        uu = {32'h0, b};
        ia = a;
        ib = b;
        r  = '0;
        case (f)
            3'd0: begin sp = sa * sb; r = sp[31:0];  end
            3'd1: begin sp = sa * sb; r = sp[63:32]; end
            3'd2: begin sp = sa * ub; r = sp[63:32]; end
            3'd3: begin up = ua * uu; r = up[63:32]; end
            3'd4: if (b == 0) r = 32'hFFFF_FFFF;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                  else r = ia / ib;
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: if (b == 0) r = a;
                  else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                  else r = ia % ib;
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 0;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return ITER_LAT;
    endfunction

    // Waits for in_ready, presents the operation and returns #1 after the accept edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            nvec++;
            nmis++;
            $display("FAIL ready_timeout: in_ready=%b, expected 1", in_ready);
        end
        in_valid = 1'b1;
        op       = f;
        in1      = a;
        in2      = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output logic ready_seen);
        issue(f, a, b);
        lat = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) ready_seen = 1'b1;
        res = out_valid ? out : 'x;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        int          lat;
        logic        rdy;
        logic        stable;
        logic        seen;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        tv[0]  = '{3'd0, 32'h0000_0006, 32'hFFFF_FFFD, 32'hFFFF_FFEE, ITER_LAT};
        tv[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ITER_LAT};
        tv[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ITER_LAT};
        tv[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ITER_LAT};
        tv[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, ITER_LAT};
        tv[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, ITER_LAT};
        tv[6]  = '{3'd5, 32'hFFFF_FFFE, 32'h0000_0002, 32'h7FFF_FFFF, ITER_LAT};
        tv[7]  = '{3'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, ITER_LAT};
        tv[8]  = '{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0};
        tv[9]  = '{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0};
        tv[10] = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0};
        tv[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};
        tv[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};
        tv[13] = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0};
        tv[14] = '{3'd0, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C, ITER_LAT};

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = '0;
        in1       = '0;
        in2       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_out",       out,            32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            run_op(tv[i].f, tv[i].a, tv[i].b, res, lat, rdy);
            $display("vec %0d: op=%0d in1=%h in2=%h out=%h latency=%0d", i, tv[i].f,
                     tv[i].a, tv[i].b, res, lat);
            check($sformatf("vec%0d_result", i), res, tv[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(tv[i].lat));
            check($sformatf("vec%0d_in_ready_low", i), 32'(rdy), 32'd0);
        end

        // backpressure: result held while the consumer stalls
        issue(3'd5, 32'd100, 32'd7);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        held   = out;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out !== held || !out_valid || in_ready) stable = 1'b0;
        end
        $display("backpressure: DIVU 100/7 out=%h", out);
        check("bp_result", held, 32'd14);
        check("bp_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release_in_ready",  32'(in_ready),  32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        run_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, res, lat, rdy);
        $display("after backpressure: MULHU out=%h", res);
        check("bp_next_result", res, ref_model(3'd3, 32'h1234_5678, 32'h9ABC_DEF0));

        // flush in the tenth CALC cycle
        issue(3'd0, 32'h0000_1234, 32'h0000_5678);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_in_ready",  32'(in_ready),  32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        $display("flush mid-CALC: out_valid seen=%b", seen);
        check("flush_no_result", 32'(seen), 32'd0);

        // asynchronous reset in the middle of CALC
        issue(3'd0, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out",       out,            32'd0);
        check("rst_mid_busy",      32'(busy),      32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        run_op(3'd0, 32'd3, 32'd4, res, lat, rdy);
        $display("after reset: MUL 3x4 out=%h", res);
        check("rst_then_mul", res, 32'h0000_000C);

        // flush wins over in_valid in IDLE
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = 3'd5;
        in1      = 32'd5;
        in2      = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        $display("flush with in_valid: busy=%b out_valid=%b out=%h", busy, out_valid, out);
        check("flush_idle_busy",      32'(busy),      32'd0);
        check("flush_idle_out_valid", 32'(out_valid), 32'd0);
        check("flush_idle_out",       out,            32'h0000_000C);

        // random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: begin a = $urandom_range(0, 255); b = $urandom_range(0, 15); end
                1: begin a = $urandom; b = 32'd0; end
                2: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op(f, a, b, res, lat, rdy);
            $display("rand %0d: op=%0d in1=%h in2=%h out=%h latency=%0d", i, f, a, b, res, lat);
            check($sformatf("rand%0d_result", i), res, ref_model(f, a, b));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(f, a, b)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
